raster_scheduler: RTL and testbench

- Sequences the triangle rasterizer_unit in the graphics pipeline and replaces the hard-wired one-triangle-per-keypress FSM.
- Queues incoming triangles in a small FIFO and issues them one at a time using the rasterizer's start/done handshake.
- On the last triangle of a frame, waits for vertical sync, then toggles the frame_director buffer select.

---
 rtl/raster_scheduler.sv | 179 +++++++++++++++++
 tb/tb_raster_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_scheduler.sv
// Triangle scheduler: queues triangles in a small FIFO, issues each to the
// rasterizer via start/done, and swaps the frame buffer on vsync after a frame's last triangle.
module raster_scheduler #(
  parameter int DEPTH        = 4,
  parameter int START_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tri_valid,
  output logic                     tri_ready,
  input  logic [95:0]              tri_p1,
  input  logic [95:0]              tri_p2,
  input  logic [95:0]              tri_p3,
  input  logic                     tri_last,
  output logic                     ru_start,
  output logic [95:0]              ru_p1,
  output logic [95:0]              ru_p2,
  output logic [95:0]              ru_p3,
  input  logic                     ru_done,
  input  logic                     vga_vs,
  output logic                     buffer_select,
  output logic                     frame_done,
  output logic [15:0]              frame_count,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(START_CYCLES + 1);
  localparam int EW = 289;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_DONE,
    S_SWAP_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              armed_q, armed_d;

  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic              full;
  logic              push;
  logic              pop;
  logic [EW-1:0]     head;

  logic              ru_start_q;
  logic [95:0]       ru_p1_q, ru_p2_q, ru_p3_q;
  logic              last_q;
  logic              buffer_select_q;
  logic              frame_done_q;
  logic [15:0]       frame_count_q;
  logic              load_en;
  logic              swap_en;

  // Input handshake: a triangle transfers on any rising clk edge where
  // tri_valid && tri_ready; tri_ready depends only on FIFO occupancy.
  assign full      = (level_q == LW'(DEPTH));
  assign tri_ready = ~full;
  assign push      = tri_valid & ~full;
  assign pop       = (state_q == S_LOAD);
  assign head      = mem_q[rd_ptr_q];

  assign load_en = (state_q == S_LOAD);
  assign swap_en = (state_q == S_SWAP_WAIT) & ~vga_vs;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {tri_p1, tri_p2, tri_p3, tri_last};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // done_armed only sets after ru_done has been seen low since this
  // triangle's START, so a done level left over from the last one is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_START;
        cnt_d   = '0;
        armed_d = 1'b0;
      end
      S_START: begin
        if (!ru_done) armed_d = 1'b1;
        if (cnt_q == CW'(START_CYCLES - 1)) begin
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!ru_done) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = last_q ? S_SWAP_WAIT : S_IDLE;
        end
      end
      S_SWAP_WAIT: begin
        if (!vga_vs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      armed_q         <= 1'b0;
      ru_start_q      <= 1'b0;
      ru_p1_q         <= '0;
      ru_p2_q         <= '0;
      ru_p3_q         <= '0;
      last_q          <= 1'b0;
      buffer_select_q <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
      ru_start_q   <= (state_d == S_START);
      frame_done_q <= swap_en;
      if (load_en) begin
        ru_p1_q <= head[288:193];
        ru_p2_q <= head[192:97];
        ru_p3_q <= head[96:1];
        last_q  <= head[0];
      end
      if (swap_en) begin
        buffer_select_q <= ~buffer_select_q;
        frame_count_q   <= frame_count_q + 16'd1;
      end
    end
  end

  assign ru_start      = ru_start_q;
  assign ru_p1         = ru_p1_q;
  assign ru_p2         = ru_p2_q;
  assign ru_p3         = ru_p3_q;
  assign buffer_select = buffer_select_q;
  assign frame_done    = frame_done_q;
  assign frame_count   = frame_count_q;
  assign fifo_level    = level_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_raster_scheduler.sv
// Directed bench for raster_scheduler: latency, FIFO full/order, stale done,
// vsync-low swap, reset mid-operation and frame counter wrap.
module tb_raster_scheduler;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          tri_valid;
  logic          tri_ready;
  logic [95:0]   tri_p1, tri_p2, tri_p3;
  logic          tri_last;
  logic          ru_start;
  logic [95:0]   ru_p1, ru_p2, ru_p3;
  logic          ru_done;
  logic          vga_vs;
  logic          buffer_select;
  logic          frame_done;
  logic [15:0]   frame_count;
  logic [LW-1:0] fifo_level;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [287:0] exp_q[$];

  raster_scheduler #(.DEPTH(DEPTH), .START_CYCLES(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .tri_valid     (tri_valid),
    .tri_ready     (tri_ready),
    .tri_p1        (tri_p1),
    .tri_p2        (tri_p2),
    .tri_p3        (tri_p3),
    .tri_last      (tri_last),
    .ru_start      (ru_start),
    .ru_p1         (ru_p1),
    .ru_p2         (ru_p2),
    .ru_p3         (ru_p3),
    .ru_done       (ru_done),
    .vga_vs        (vga_vs),
    .buffer_select (buffer_select),
    .frame_done    (frame_done),
    .frame_count   (frame_count),
    .fifo_level    (fifo_level),
    .busy          (busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: offer one triangle for one cycle
  task automatic push_tri(input logic [95:0] p1, input logic [95:0] p2,
                          input logic [95:0] p3, input logic last);
    tri_valid = 1'b1;
    tri_p1    = p1;
    tri_p2    = p2;
    tri_p3    = p3;
    tri_last  = last;
    tick();
    tri_valid = 1'b0;
  endtask

  task automatic wait_start(input logic lvl);
    int n = 0;
    while (ru_start !== lvl && n < 64) begin
      tick();
      n++;
    end
    chk_bit("ru_start_wait", ru_start, lvl);
  endtask

  task automatic done_pulse();
    ru_done = 1'b1;
    tick();
    ru_done = 1'b0;
  endtask

  // one complete last-of-frame triangle with vga_vs already low
  task automatic run_frame(input logic [95:0] p);
    push_tri(p, p, p, 1'b1);
    wait_start(1'b1);
    wait_start(1'b0);
    done_pulse();
    tick();
  endtask

  localparam logic [95:0] T1P1 = {32'h428a0000, 32'h428a0000, 32'h3f800000};
  localparam logic [95:0] T1P2 = {32'h40000000, 32'h41200000, 32'h3f800000};
  localparam logic [95:0] T1P3 = {32'h41a00000, 32'h40a00000, 32'h3f800000};
  localparam logic [95:0] TA   = {3{32'hAAAA0001}};
  localparam logic [95:0] TB   = {3{32'hBBBB0002}};

  initial begin
    int lvl_tab[6];
    logic [287:0] e;
    logic [95:0] p1, p2, p3;

    lvl_tab = '{1, 2, 2, 3, 4, 4};
    reset = 1'b1; tri_valid = 1'b0; tri_p1 = '0; tri_p2 = '0; tri_p3 = '0;
    tri_last = 1'b0; ru_done = 1'b0; vga_vs = 1'b1;
    tick();
    tick();

    chk_bit("rst_tri_ready", tri_ready, 1'b1);
    chk_vec("rst_fifo_level", 96'(fifo_level), 96'(0));
    chk_bit("rst_ru_start", ru_start, 1'b0);
    chk_vec("rst_ru_p1", ru_p1, '0);
    chk_bit("rst_buffer_select", buffer_select, 1'b0);
    chk_bit("rst_frame_done", frame_done, 1'b0);
    chk_vec("rst_frame_count", 96'(frame_count), 96'(0));
    chk_bit("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // single-triangle frame, latency of ru_start
    push_tri(T1P1, T1P2, T1P3, 1'b1);
    chk_vec("t1_level_after_push", 96'(fifo_level), 96'(1));
    chk_bit("t1_idle_busy", busy, 1'b0);
    tick();
    chk_bit("t1_load_busy", busy, 1'b1);
    chk_bit("t1_load_start", ru_start, 1'b0);
    tick();
    chk_bit("t1_start_e2", ru_start, 1'b1);
    chk_vec("t1_ru_p1", ru_p1, T1P1);
    chk_vec("t1_ru_p2", ru_p2, T1P2);
    chk_vec("t1_ru_p3", ru_p3, T1P3);
    chk_vec("t1_level_after_pop", 96'(fifo_level), 96'(0));
    tick();
    chk_bit("t1_start_e3", ru_start, 1'b1);
    tick();
    chk_bit("t1_start_e4", ru_start, 1'b1);
    tick();
    chk_bit("t1_start_e5", ru_start, 1'b0);
    repeat (15) tick();
    ru_done = 1'b1;
    tick();
    ru_done = 1'b0;
    chk_bit("t1_swapwait_busy", busy, 1'b1);
    chk_bit("t1_swapwait_bufsel", buffer_select, 1'b0);
    repeat (3) tick();
    chk_bit("t1_vs_high_bufsel", buffer_select, 1'b0);
    chk_bit("t1_vs_high_fdone", frame_done, 1'b0);
    vga_vs = 1'b0;
    tick();
    vga_vs = 1'b1;
    chk_bit("t1_swap_bufsel", buffer_select, 1'b1);
    chk_bit("t1_swap_fdone", frame_done, 1'b1);
    chk_vec("t1_swap_fcount", 96'(frame_count), 96'(1));
    chk_bit("t1_swap_busy", busy, 1'b0);
    tick();
    chk_bit("t1_fdone_single", frame_done, 1'b0);

    // FIFO full with rasterizer stalled; expect 5 accepted, issued in order
    for (int i = 0; i < 6; i++) begin
      p1 = {3{32'h10000000 + 32'(i)}};
      p2 = {3{32'h20000000 + 32'(i)}};
      p3 = {3{32'h30000000 + 32'(i)}};
      tri_valid = 1'b1; tri_p1 = p1; tri_p2 = p2; tri_p3 = p3; tri_last = 1'b0;
      chk_bit("full_tri_ready", tri_ready, (i < 5));
      if (i < 5) exp_q.push_back({p1, p2, p3});
      tick();
      chk_vec("full_level", 96'(fifo_level), 96'(lvl_tab[i]));
    end
    tri_valid = 1'b0;
    chk_bit("full_ready_low", tri_ready, 1'b0);
    for (int k = 0; k < 5; k++) begin
      e = exp_q.pop_front();
      if (k > 0) wait_start(1'b1);
      chk_vec("order_p1", ru_p1, e[287:192]);
      chk_vec("order_p2", ru_p2, e[191:96]);
      chk_vec("order_p3", ru_p3, e[95:0]);
      wait_start(1'b0);
      done_pulse();
    end
    tick();
    chk_bit("full_drained_busy", busy, 1'b0);
    chk_vec("full_drained_level", 96'(fifo_level), 96'(0));

    // stale done held across a triangle boundary
    push_tri(TA, TA, TA, 1'b0);
    push_tri(TB, TB, TB, 1'b0);
    wait_start(1'b1);
    chk_vec("stale_a_p1", ru_p1, TA);
    wait_start(1'b0);
    ru_done = 1'b1;
    repeat (12) tick();
    chk_vec("stale_b_loaded", ru_p1, TB);
    chk_bit("stale_b_start_done", ru_start, 1'b0);
    chk_bit("stale_held_busy", busy, 1'b1);
    ru_done = 1'b0;
    tick();
    chk_bit("stale_low_busy", busy, 1'b1);
    ru_done = 1'b1;
    tick();
    ru_done = 1'b0;
    chk_bit("stale_rearmed_idle", busy, 1'b0);

    // vsync already low when the last triangle finishes
    vga_vs = 1'b0;
    push_tri(T1P1, T1P2, T1P3, 1'b1);
    wait_start(1'b1);
    wait_start(1'b0);
    done_pulse();
    chk_bit("vslow_entry_busy", busy, 1'b1);
    chk_bit("vslow_entry_bufsel", buffer_select, 1'b1);
    chk_bit("vslow_entry_fdone", frame_done, 1'b0);
    tick();
    chk_bit("vslow_swap_bufsel", buffer_select, 1'b0);
    chk_bit("vslow_swap_fdone", frame_done, 1'b1);
    chk_vec("vslow_swap_fcount", 96'(frame_count), 96'(2));
    chk_bit("vslow_swap_busy", busy, 1'b0);

    // reset during START with two queued and buffer_select high
    run_frame(T1P2);
    chk_bit("pre_rst_bufsel", buffer_select, 1'b1);
    chk_vec("pre_rst_fcount", 96'(frame_count), 96'(3));
    vga_vs = 1'b1;
    push_tri(TA, TA, TA, 1'b0);
    push_tri(TB, TB, TB, 1'b0);
    push_tri(T1P3, T1P3, T1P3, 1'b0);
    chk_bit("pre_rst_start", ru_start, 1'b1);
    chk_vec("pre_rst_level", 96'(fifo_level), 96'(2));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_bit("midrst_ru_start", ru_start, 1'b0);
    chk_vec("midrst_level", 96'(fifo_level), 96'(0));
    chk_bit("midrst_bufsel", buffer_select, 1'b0);
    chk_vec("midrst_fcount", 96'(frame_count), 96'(0));
    chk_bit("midrst_busy", busy, 1'b0);
    chk_vec("midrst_ru_p1", ru_p1, '0);

    // frame_count wrap from a forced 0xFFFF
    force dut.frame_count_q = 16'hFFFF;
    #1;
    release dut.frame_count_q;
    chk_vec("wrap_preload", 96'(frame_count), 96'(16'hFFFF));
    vga_vs = 1'b0;
    run_frame(TA);
    chk_vec("wrap_fcount", 96'(frame_count), 96'(0));
    chk_bit("wrap_fdone", frame_done, 1'b1);
    chk_bit("wrap_bufsel", buffer_select, 1'b1);
    tick();
    chk_bit("wrap_fdone_clear", frame_done, 1'b0);
    vga_vs = 1'b1;

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
